life_ctrl: RTL

- Control sequencer directly upstream of the life engine; drives its raddr/waddr/we/re/ld/init pins.
- Sweeps one generation in place over the cell RAM, sequences bulk initialisation, and inserts single-row video reads that latch the engine's 256-bit display word.
- Counts completed generations for the on-screen counter.
- Runs on the clk4 domain. vid_req is already synchronised into this domain by its producer.

---
 rtl/life_pkg.sv | 16 +
 rtl/life_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/life_pkg.sv
// Shared types and slot constants for the life engine control sequencer.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    SWEEP = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int VID_RD_PHASE  = 2;
  localparam int VID_LD_PHASE  = 3;
  localparam int WR_START_STEP = 3;
  localparam int FIRST_WR_ROW  = 1;

endpackage

// File: rtl/life_ctrl.sv
// Sequences generation sweeps, bulk init and video row loads for the life engine.
// Outputs are registered and computed from the next-cycle state, phase and step.
module life_ctrl
  import life_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int DBITS   = 8,
  parameter int ROW_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             run,
  input  logic             init_req,
  input  logic             vid_req,
  input  logic [DBITS-1:0] vid_row,
  output logic [DBITS-1:0] raddr,
  output logic [DBITS-1:0] waddr,
  output logic             we,
  output logic             re,
  output logic             ld,
  output logic             init,
  output logic             vid_ack,
  output logic             busy,
  output logic             gen_done,
  output logic [47:0]      gen_count
);

  localparam int PBITS = (ROW_CYC > 1) ? $clog2(ROW_CYC) : 1;
  localparam logic [PBITS-1:0] PH_LAST  = PBITS'(ROW_CYC - 1);
  localparam logic [PBITS-1:0] PH_VRD   = PBITS'(VID_RD_PHASE);
  localparam logic [PBITS-1:0] PH_VLD   = PBITS'(VID_LD_PHASE);
  localparam logic [DBITS-1:0] ROW_LAST = DBITS'(DEPTH - 1);
  localparam logic [DBITS-1:0] DRAIN_WR = DBITS'(DEPTH - 2);
  localparam logic [DBITS-1:0] WR_STEP  = DBITS'(WR_START_STEP);
  localparam logic [DBITS-1:0] WR_LAG   = DBITS'(WR_START_STEP - FIRST_WR_ROW);

  state_e           state_q, state_d;
  logic [PBITS-1:0] phase_q, phase_d;
  logic [DBITS-1:0] step_q, step_d;
  logic             pend_start_q, pend_start_d;
  logic             pend_init_q, pend_init_d;
  logic             vid_rd_q, vid_rd_d;
  logic [DBITS-1:0] raddr_q, raddr_d;
  logic [DBITS-1:0] waddr_q, waddr_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic             ld_q, ld_d;
  logic             init_q, init_d;
  logic             busy_q, busy_d;
  logic             gen_done_q, gen_done_d;
  logic [47:0]      gen_count_q, gen_count_d;
  logic             init_want, enter_init, enter_sweep;

  always_comb begin
    phase_d     = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    state_d     = state_q;
    step_d      = step_q;
    enter_init  = 1'b0;
    enter_sweep = 1'b0;
    init_want   = init_req | pend_init_q;

    case (state_q)
      IDLE: begin
        if (init_want) begin
          state_d    = INIT;
          step_d     = '0;
          enter_init = 1'b1;
        end else if ((start | pend_start_q | run) && phase_q == PH_LAST) begin
          state_d     = SWEEP;
          step_d      = '0;
          enter_sweep = 1'b1;
        end
      end
      INIT: begin
        step_d = step_q + 1'b1;
        if (step_q == ROW_LAST) state_d = IDLE;
      end
      SWEEP: begin
        if (phase_q == PH_LAST) begin
          if (step_q == ROW_LAST) state_d = DRAIN;
          else                    step_d  = step_q + 1'b1;
        end
      end
      DRAIN: begin
        if (phase_q == PH_LAST) begin
          if (run && !init_want) begin
            state_d     = SWEEP;
            step_d      = '0;
            enter_sweep = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A request arriving in the same cycle it is serviced is consumed.
    pend_start_d = (pend_start_q | start) & ~enter_sweep;
    pend_init_d  = (pend_init_q | init_req) & ~enter_init;

    raddr_d    = raddr_q;
    waddr_d    = waddr_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    init_d     = 1'b0;
    gen_done_d = 1'b0;

    case (state_d)
      INIT: begin
        we_d    = 1'b1;
        init_d  = 1'b1;
        waddr_d = step_d;
      end
      SWEEP: begin
        if (phase_d == '0) begin
          re_d    = 1'b1;
          raddr_d = step_d;
          // Row k-2 is written once row k is in the engine's window.
          if (step_d >= WR_STEP) begin
            we_d    = 1'b1;
            waddr_d = step_d - WR_LAG;
          end
        end
      end
      DRAIN: begin
        if (phase_d == '0) begin
          we_d       = 1'b1;
          waddr_d    = DRAIN_WR;
          gen_done_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Video slot never lands on phase 0, so it cannot collide with re.
    vid_rd_d = (phase_d == PH_VRD) && vid_req;
    if (vid_rd_d) raddr_d = vid_row;
    ld_d = (phase_d == PH_VLD) && vid_rd_q;

    busy_d      = (state_d != IDLE);
    gen_count_d = gen_count_q + {47'd0, gen_done_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      step_q       <= '0;
      pend_start_q <= 1'b0;
      pend_init_q  <= 1'b0;
      vid_rd_q     <= 1'b0;
      raddr_q      <= '0;
      waddr_q      <= '0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      ld_q         <= 1'b0;
      init_q       <= 1'b0;
      busy_q       <= 1'b0;
      gen_done_q   <= 1'b0;
      gen_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      step_q       <= step_d;
      pend_start_q <= pend_start_d;
      pend_init_q  <= pend_init_d;
      vid_rd_q     <= vid_rd_d;
      raddr_q      <= raddr_d;
      waddr_q      <= waddr_d;
      we_q         <= we_d;
      re_q         <= re_d;
      ld_q         <= ld_d;
      init_q       <= init_d;
      busy_q       <= busy_d;
      gen_done_q   <= gen_done_d;
      gen_count_q  <= gen_count_d;
    end
  end

  assign raddr     = raddr_q;
  assign waddr     = waddr_q;
  assign we        = we_q;
  assign re        = re_q;
  assign ld        = ld_q;
  assign vid_ack   = ld_q;
  assign init      = init_q;
  assign busy      = busy_q;
  assign gen_done  = gen_done_q;
  assign gen_count = gen_count_q;

endmodule
